arm_shift_mul_unit: RTL

Parametrised multi-cycle execution unit for the ARM datapath. It performs the barrel-shift operations (LSL, LSR, ASR, ROR) and 32x32→32 MUL iteratively, processing STEP bits per cycle, and produces NZCV flags in ARM semantics. It sits beside the ALU. The controller stalls the PC on busy and selects the unit's result and flags when done is high.

---
 rtl/arm_xu_pkg.sv | 23 ++
 rtl/shift_step.sv | 49 ++++
 rtl/arm_shift_mul_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/arm_xu_pkg.sv
// Shared types and constants for the ARM execution-unit slice.
package arm_xu_pkg;

    typedef enum logic [2:0] {
        LSL = 3'b000,
        LSR = 3'b001,
        ASR = 3'b010,
        ROR = 3'b011,
        MUL = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/shift_step.sv
// One iteration of the shifter: shifts a WIDTH value by k (0..STEP) and reports the last bit out.
module shift_step
    import arm_xu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    localparam int unsigned KW   = $clog2(STEP + 1)
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] value,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] shifted,
    output logic             bit_out
);

    logic [WIDTH-1:0] sel;

    // sel is a one-hot mask on the bit that leaves the word last
    always_comb begin
        shifted = value;
        sel     = '0;
        if (k != '0) begin
            case (op)
                LSL: begin
                    shifted = value << k;
                    sel     = WIDTH'(1) << (WIDTH - k);
                end
                LSR: begin
                    shifted = value >> k;
                    sel     = WIDTH'(1) << (k - KW'(1));
                end
                ASR: begin
                    shifted = $signed(value) >>> k;
                    sel     = WIDTH'(1) << (k - KW'(1));
                end
                ROR: begin
                    shifted = (value >> k) | (value << (WIDTH - k));
                    sel     = WIDTH'(1) << (k - KW'(1));
                end
                default: begin
                    shifted = value;
                    sel     = '0;
                end
            endcase
        end
        bit_out = |(value & sel);
    end

endmodule

// File: rtl/arm_shift_mul_unit.sv
// Iterative barrel-shift / shift-add multiply unit producing ARM NZCV flags.
module arm_shift_mul_unit
    import arm_xu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       flags_in,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             done,
    output logic             busy
);

    localparam int unsigned KW  = $clog2(STEP + 1);
    localparam int unsigned CW  = $clog2(WIDTH + 2);
    localparam int unsigned SSH = $clog2(STEP);

    state_e           state, state_nxt;
    logic [2:0]       op_q, op_nxt, step_op;
    logic [WIDTH-1:0] acc_q, acc_nxt, prod_q, prod_nxt, mplier_q, mplier_nxt;
    logic [WIDTH-1:0] pp, pp_ac, pp_mp, step_out, res_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt, iters;
    logic [KW-1:0]    rem_q, rem_nxt, rem_c, k;
    logic             carry_q, carry_nxt, step_bit;
    logic [3:0]       fin_q, fin_nxt, flags_nxt;
    int unsigned      n_raw, n_eff;

    // Clamped shift amount and iteration count for the incoming request
    always_comb begin
        n_raw = 32'(b[7:0]);
        n_eff = 0;
        case (op)
            LSL, LSR: n_eff = (n_raw > WIDTH + 1) ? WIDTH + 1 : n_raw;
            ASR:      n_eff = (n_raw > WIDTH) ? WIDTH : n_raw;
            ROR:      n_eff = n_raw & (WIDTH - 1);
            MUL:      n_eff = WIDTH;
            default:  n_eff = 0;
        endcase
        iters = CW'((n_eff + STEP - 1) >> SSH);
        rem_c = KW'(n_eff & (STEP - 1));
    end

    // Final step of a shift moves only the remainder; MUL always takes full steps
    always_comb begin
        k       = (cnt_q == CW'(1) && rem_q != '0) ? rem_q : KW'(STEP);
        step_op = (op_q == MUL) ? 3'(LSL) : op_q;
        pp      = '0;
        pp_ac   = acc_q;
        pp_mp   = mplier_q;
        for (int i = 0; i < int'(STEP); i++) begin
            if (pp_mp[0]) pp = pp + pp_ac;
            pp_ac = pp_ac << 1;
            pp_mp = pp_mp >> 1;
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .op      (step_op),
        .value   (acc_q),
        .k       (k),
        .shifted (step_out),
        .bit_out (step_bit)
    );

    // Next-state and datapath update
    always_comb begin
        state_nxt  = state;
        op_nxt     = op_q;
        acc_nxt    = acc_q;
        prod_nxt   = prod_q;
        mplier_nxt = mplier_q;
        cnt_nxt    = cnt_q;
        rem_nxt    = rem_q;
        carry_nxt  = carry_q;
        fin_nxt    = fin_q;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    op_nxt     = op;
                    acc_nxt    = a;
                    prod_nxt   = '0;
                    mplier_nxt = b;
                    cnt_nxt    = iters;
                    rem_nxt    = rem_c;
                    fin_nxt    = flags_in;
                    // A nonzero multiple-of-WIDTH rotate does no work but still reports the MSB
                    carry_nxt  = (op == ROR && b[7:0] != 8'd0) ? a[WIDTH-1] : flags_in[FLAG_C];
                    state_nxt  = (iters == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                acc_nxt = step_out;
                cnt_nxt = cnt_q - CW'(1);
                if (op_q == MUL) begin
                    prod_nxt   = prod_q + pp;
                    mplier_nxt = mplier_q >> STEP;
                end else begin
                    carry_nxt = step_bit;
                end
                if (cnt_q == CW'(1)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result and flags as they will stand when DONE is entered
    always_comb begin
        res_nxt   = acc_nxt;
        flags_nxt = fin_nxt;
        case (op_nxt)
            LSL, LSR, ASR, ROR: begin
                flags_nxt[FLAG_N] = acc_nxt[WIDTH-1];
                flags_nxt[FLAG_Z] = (acc_nxt == '0);
                flags_nxt[FLAG_C] = carry_nxt;
            end
            MUL: begin
                res_nxt           = prod_nxt;
                flags_nxt[FLAG_N] = prod_nxt[WIDTH-1];
                flags_nxt[FLAG_Z] = (prod_nxt == '0);
            end
            default: begin
                res_nxt   = acc_nxt;
                flags_nxt = fin_nxt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q        <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            carry_q     <= 1'b0;
            fin_q       <= '0;
            result      <= '0;
            flags       <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            op_q        <= op_nxt;
            acc_q       <= acc_nxt;
            prod_q      <= prod_nxt;
            mplier_q    <= mplier_nxt;
            cnt_q       <= cnt_nxt;
            rem_q       <= rem_nxt;
            carry_q     <= carry_nxt;
            fin_q       <= fin_nxt;
            done        <= (state_nxt == DONE);
            busy        <= (state_nxt != IDLE);
            start_ready <= (state_nxt == IDLE);
            if (state_nxt == DONE) begin
                result <= res_nxt;
                flags  <= flags_nxt;
            end
        end
    end

endmodule
